gf64_power_engine: RTL and testbench



---
 rtl/gf64_power_engine_if.sv | 22 ++
 rtl/gf64_power_engine.sv | 169 ++++++++++++++++
 tb/tb_gf64_power_engine.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/gf64_power_engine_if.sv
// Handshake bundle for gf64_power_engine: request side (x, e) and result side (y).
interface gf64_power_engine_if #(
  parameter int EXP_W = 6
) ();
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       x;
  logic [EXP_W-1:0] e;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       y;

  modport master (
    output in_valid, x, e, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, e, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/gf64_power_engine.sv
// y = x^e over GF(2^6) (poly basis, x^6+x+1) by MSB-first square-and-multiply in GF((2^3)^2).
// Optional macro GF64_POWER_EARLY_EXIT_EN starts at the leading one of e instead of bit EXP_W-1.
module gf64_power_engine #(
  parameter int EXP_W = 6
) (
  input logic                clk,
  input logic                rst,
  gf64_power_engine_if.slave bus
);

  localparam int         IDX_W     = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [5:0] TOWER_ONE = 6'b000_001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Base field GF(2^3) mod a^3+a+1.
  function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
    logic c0, c1, c2, c3, c4;
    c0 = a[0] & b[0];
    c1 = (a[1] & b[0]) ^ (a[0] & b[1]);
    c2 = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]);
    c3 = (a[2] & b[1]) ^ (a[1] & b[2]);
    c4 = a[2] & b[2];
    return {c2 ^ c4, c1 ^ c3 ^ c4, c0 ^ c3};
  endfunction

  function automatic logic [2:0] gf8_sq(input logic [2:0] a);
    return {a[1] ^ a[2], a[2], a[0]};
  endfunction

  // Tower element {h, l} = h*Y + l with Y^2 = Y + 1; Karatsuba with three base multiplies.
  function automatic logic [5:0] tower_mul(input logic [5:0] a, input logic [5:0] b);
    logic [2:0] hh, ll, mm;
    hh = gf8_mul(a[5:3], b[5:3]);
    ll = gf8_mul(a[2:0], b[2:0]);
    mm = gf8_mul(a[5:3] ^ a[2:0], b[5:3] ^ b[2:0]);
    return {mm ^ ll, hh ^ ll};
  endfunction

  function automatic logic [5:0] tower_sq(input logic [5:0] a);
    logic [2:0] hs, ls;
    hs = gf8_sq(a[5:3]);
    ls = gf8_sq(a[2:0]);
    return {hs, hs ^ ls};
  endfunction

  // Isomorphism pair: a -> alpha^27, Y -> alpha^21 where alpha is a root of x^6+x+1.
  function automatic logic [5:0] iso(input logic [5:0] p);
    logic h0, h1, h2, l0, l1, l2;
    h0 = p[5];
    h1 = p[1] ^ p[3] ^ p[4] ^ p[5];
    h2 = p[2] ^ p[3] ^ p[4];
    l2 = p[4] ^ p[5];
    l1 = p[1] ^ p[4];
    l0 = p[0] ^ p[1] ^ p[2] ^ p[4] ^ p[5];
    return {h2, h1, h0, l2, l1, l0};
  endfunction

  function automatic logic [5:0] inv_iso(input logic [5:0] t);
    logic h0, h1, h2, l0, l1, l2;
    {h2, h1, h0, l2, l1, l0} = t;
    return {h0,
            l2 ^ h0,
            l1 ^ h0 ^ h1,
            l1 ^ l2 ^ h1 ^ h2,
            l1 ^ l2 ^ h0,
            l0 ^ l2 ^ h0 ^ h1 ^ h2};
  endfunction

`ifdef GF64_POWER_EARLY_EXIT_EN
  function automatic logic [IDX_W-1:0] start_index(input logic [EXP_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < EXP_W; k++) begin
      if (v[k]) idx = IDX_W'(k);
    end
    return idx;
  endfunction
`else
  function automatic logic [IDX_W-1:0] start_index(input logic [EXP_W-1:0] v);
    logic unused_v;
    unused_v = ^v;
    return IDX_W'(EXP_W - 1);
  endfunction
`endif

  state_t           state_q, state_d;
  logic [5:0]       w_q, w_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [5:0]       acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [5:0]       y_q, y_d;
  logic [5:0]       acc_step;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    e_d         = e_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    acc_step    = tower_mul(tower_sq(acc_q), e_q[idx_q] ? w_q : TOWER_ONE);

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          w_d        = iso(bus.x);
          e_d        = bus.e;
          acc_d      = TOWER_ONE;
          idx_d      = start_index(bus.e);
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        if (idx_q == '0) state_d = DONE;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      DONE: begin
        // First DONE cycle loads y; the result is then shown for at least one full cycle.
        if (!out_valid_q) begin
          y_d         = inv_iso(acc_q);
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w_q         <= '0;
      e_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      e_q         <= e_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;

endmodule

// File: tb/tb_gf64_power_engine.sv
// Directed bench for gf64_power_engine (EXP_W=6 and EXP_W=12 instances) against a poly-basis model.
module tb_gf64_power_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf64_power_engine_if #(.EXP_W(6))  bus6 ();
  gf64_power_engine_if #(.EXP_W(12)) bus12 ();

  gf64_power_engine #(.EXP_W(6))  u_dut6  (.clk(clk), .rst(rst), .bus(bus6));
  gf64_power_engine #(.EXP_W(12)) u_dut12 (.clk(clk), .rst(rst), .bus(bus12));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0] x;
    logic [5:0] e;
    logic [5:0] y;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pmul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r, aa;
    r  = 6'h00;
    aa = a;
    for (int k = 0; k < 6; k++) begin
      if (b[k]) r = r ^ aa;
      aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
    end
    return r;
  endfunction

  function automatic logic [5:0] model_pow(input logic [5:0] xv, input int ev);
    logic [5:0] r;
    r = 6'h01;
    for (int k = 0; k < ev; k++) r = pmul(r, xv);
    return r;
  endfunction

  function automatic int exp_lat(input int ev, input int w);
`ifdef GF64_POWER_EARLY_EXIT_EN
    int bl;
    bl = 0;
    for (int k = 0; k < w; k++) if (((ev >> k) & 1) == 1) bl = k + 1;
    if (bl == 0) bl = 1;
    return bl + 1;
`else
    return (ev >= 0) ? w + 1 : w + 1;
`endif
  endfunction

  // Called at posedge+1 with the engine idle; returns y and the accept-to-out_valid edge count.
  task automatic txn6(input logic [5:0] xi, input logic [5:0] ei, input bit hold_ready,
                      output logic [5:0] yo, output int lat);
    bus6.x         = xi;
    bus6.e         = ei;
    bus6.in_valid  = 1'b1;
    bus6.out_ready = hold_ready;
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    bus6.x        = ~xi;
    bus6.e        = ~ei;
    lat = 0;
    while (!bus6.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    yo = bus6.y;
    bus6.out_ready = 1'b1;
    @(posedge clk); #1;
    bus6.out_ready = 1'b0;
  endtask

  task automatic txn12(input logic [5:0] xi, input logic [11:0] ei,
                       output logic [5:0] yo, output int lat);
    bus12.x        = xi;
    bus12.e        = ei;
    bus12.in_valid = 1'b1;
    @(posedge clk); #1;
    bus12.in_valid = 1'b0;
    bus12.x        = ~xi;
    bus12.e        = ~ei;
    lat = 0;
    while (!bus12.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    yo = bus12.y;
    bus12.out_ready = 1'b1;
    @(posedge clk); #1;
    bus12.out_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] yv, y0;
    int         lat;

    vecs[0]  = '{6'h00, 6'd0,  6'h01};
    vecs[1]  = '{6'h00, 6'd20, 6'h00};
    vecs[2]  = '{6'h01, 6'd63, 6'h01};
    vecs[3]  = '{6'h2B, 6'd1,  6'h2B};
    vecs[4]  = '{6'h02, 6'd6,  6'h03};
    vecs[5]  = '{6'h02, 6'd20, 6'h3C};
    vecs[6]  = '{6'h03, 6'd2,  6'h05};
    vecs[7]  = '{6'h18, 6'd7,  6'h01};
    vecs[8]  = '{6'h0E, 6'd3,  6'h0F};
    vecs[9]  = '{6'h20, 6'd13, 6'h04};
    vecs[10] = '{6'h3C, 6'd20, 6'h35};
    vecs[11] = '{6'h02, 6'd63, 6'h01};
    vecs[12] = '{6'h3B, 6'd3,  6'h01};
    vecs[13] = '{6'h11, 6'd0,  6'h01};
    vecs[14] = '{6'h23, 6'd45, 6'h17};
    vecs[15] = '{6'h05, 6'd5,  6'h39};

    bus6.in_valid   = 1'b0; bus6.x  = '0; bus6.e  = '0; bus6.out_ready  = 1'b0;
    bus12.in_valid  = 1'b0; bus12.x = '0; bus12.e = '0; bus12.out_ready = 1'b0;

    #12;
    check("reset_in_ready",  int'(bus6.in_ready),  1);
    check("reset_out_valid", int'(bus6.out_valid), 0);
    check("reset_y",         int'(bus6.y),         0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      txn6(vecs[i].x, vecs[i].e, 1'b0, yv, lat);
      check($sformatf("vec%0d_y", i),   int'(yv), int'(vecs[i].y));
      check($sformatf("vec%0d_lat", i), lat,      exp_lat(int'(vecs[i].e), 6));
    end

    // out_ready already high on DONE entry: one full cycle of out_valid, then idle.
    txn6(6'h02, 6'd20, 1'b1, yv, lat);
    check("hold_ready_y",   int'(yv), 32'h3C);
    check("hold_ready_lat", lat,      exp_lat(20, 6));
    check("hold_ready_ov_after", int'(bus6.out_valid), 0);
    check("hold_ready_ir_after", int'(bus6.in_ready),  1);

    // Backpressure with ignored in_valid pulses.
    bus6.x = 6'h2B; bus6.e = 6'd1; bus6.in_valid = 1'b1;
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    lat = 0;
    while (!bus6.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_lat", lat, exp_lat(1, 6));
    y0 = bus6.y;
    check("bp_y", int'(y0), 32'h2B);
    for (int c = 0; c < 10; c++) begin
      bus6.in_valid = c[0];
      bus6.x = 6'h00; bus6.e = 6'd0;
      @(posedge clk); #1;
      check($sformatf("bp_ov_c%0d", c), int'(bus6.out_valid), 1);
      check($sformatf("bp_y_c%0d", c),  int'(bus6.y),         int'(y0));
      check($sformatf("bp_ir_c%0d", c), int'(bus6.in_ready),  0);
    end
    bus6.in_valid = 1'b0; bus6.out_ready = 1'b1;
    @(posedge clk); #1;
    bus6.out_ready = 1'b0;
    check("bp_release_ov", int'(bus6.out_valid), 0);
    check("bp_release_ir", int'(bus6.in_ready),  1);
    txn6(6'h03, 6'd2, 1'b0, yv, lat);
    check("bp_next_y", int'(yv), 32'h05);

    // Reset on RUN cycle 3.
    bus6.x = 6'h3C; bus6.e = 6'd20; bus6.in_valid = 1'b1;
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("rst_run_ir", int'(bus6.in_ready),  1);
    check("rst_run_ov", int'(bus6.out_valid), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset while DONE is presenting a result.
    bus6.x = 6'h02; bus6.e = 6'd6; bus6.in_valid = 1'b1;
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    lat = 0;
    while (!bus6.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("rst_done_pre_ov", int'(bus6.out_valid), 1);
    #2; rst = 1'b1; #1;
    check("rst_done_ov", int'(bus6.out_valid), 0);
    check("rst_done_ir", int'(bus6.in_ready),  1);
    check("rst_done_y",  int'(bus6.y),         0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    txn6(6'h05, 6'd2, 1'b0, yv, lat);
    check("post_rst_y",   int'(yv), int'(model_pow(6'h05, 2)));
    check("post_rst_lat", lat,      exp_lat(2, 6));

    // Full (x, e) sweep against the polynomial-basis model.
    for (int xi = 0; xi < 64; xi++) begin
      for (int ei = 0; ei < 64; ei++) begin
        txn6(6'(xi), 6'(ei), 1'b0, yv, lat);
        check($sformatf("sweep_x%0h_e%0d", xi, ei), int'(yv), int'(model_pow(6'(xi), ei)));
        if (lat != exp_lat(ei, 6))
          check($sformatf("sweep_lat_x%0h_e%0d", xi, ei), lat, exp_lat(ei, 6));
        if (ei == 63 && xi != 0)
          check($sformatf("order_x%0h", xi), int'(yv), 1);
      end
    end

    // Wide exponent instance.
    txn12(6'h02, 12'hFC0, yv, lat);
    check("w12_fc0_y",   int'(yv), 1);
    check("w12_fc0_lat", lat,      exp_lat(12'hFC0, 12));
    txn12(6'h02, 12'd64, yv, lat);
    check("w12_64_y",   int'(yv), 32'h02);
    check("w12_64_lat", lat,      exp_lat(64, 12));
    txn12(6'h2B, 12'hFFF, yv, lat);
    check("w12_fff_y",  int'(yv), int'(model_pow(6'h2B, 12'hFFF)));
    txn12(6'h00, 12'd0, yv, lat);
    check("w12_zero_y",   int'(yv), 1);
    check("w12_zero_lat", lat,      exp_lat(0, 12));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
